// File: rtl/cla_seq_div_pkg.sv
// Shared definitions for the multicycle restoring divider: FSM state
// encoding, default width, counter sizing and the divide-by-zero fill value.
// Signed operation is enabled by defining CLA_SEQ_DIV_SIGNED_EN.
package cla_seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Iteration counter must hold values up to WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Every bit of the divide-by-zero quotient takes this value (all ones).
    localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/cla_seq_div_addsub.sv
// Combinational N-bit carry-lookahead adder with subtract control.
// With sub=1 it computes a - b as a + ~b + 1; cout=1 then means no borrow.
// Carries come from a parallel-prefix (Kogge-Stone) generate/propagate tree.
module CLA_AddSub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_eff;
    logic [N:0]   result;

    assign b_eff = sub ? ~b : b;

    // Prefix tree folds the carry-in into bit 0, so group generate at i is carry out of bit i.
    function automatic logic [N:0] cla_add(input logic [N-1:0] op_a,
                                           input logic [N-1:0] op_b,
                                           input logic         cin);
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] g_n;
        logic [N-1:0] p_n;
        logic [N-1:0] p_bit;
        logic [N:0]   carry;
        g     = op_a & op_b;
        p     = op_a ^ op_b;
        p_bit = p;
        g[0]  = g[0] | (p[0] & cin);
        for (int d = 1; d < N; d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int i = d; i < N; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        carry[0]   = cin;
        carry[N:1] = g;
        return {carry[N], p_bit ^ carry[N-1:0]};
    endfunction

    // Single combinational add/sub evaluation.
    always_comb begin
        result = cla_add(a, b_eff, sub);
    end

    assign sum  = result[N-1:0];
    assign cout = result[N];

endmodule

// File: rtl/cla_seq_div.sv
// Multicycle restoring divider, one quotient bit per clock, start/done handshake.
// Latency is WIDTH+1 cycles from accepted start to done.
// Define CLA_SEQ_DIV_SIGNED_EN for two's complement operands (truncating division,
// remainder takes the sign of the dividend).
module cla_seq_div
    import cla_seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             divZero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             unused_trial_msb;

    // Partial remainder shifted left with the next dividend bit from the top of quo.
    assign rem_shift = {rem, quo[WIDTH-1]};

    CLA_AddSub #(.N(WIDTH + 1)) u_trial (
        .a    (rem_shift),
        .b    ({1'b0, dvs}),
        .sub  (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    // When the subtraction succeeds the result is below the divisor, so its top bit is always zero.
    assign unused_trial_msb = trial[WIDTH];

`ifdef CLA_SEQ_DIV_SIGNED_EN
    logic [WIDTH-1:0] x_neg;
    logic [WIDTH-1:0] y_neg;
    logic [WIDTH-1:0] q_neg;
    logic [WIDTH-1:0] r_neg;
    logic             neg_q;
    logic             neg_r;
    logic             unused_cout_x;
    logic             unused_cout_y;
    logic             unused_cout_q;
    logic             unused_cout_r;

    CLA_AddSub #(.N(WIDTH)) u_neg_x (
        .a ('0), .b (x), .sub (1'b1), .sum (x_neg), .cout (unused_cout_x)
    );
    CLA_AddSub #(.N(WIDTH)) u_neg_y (
        .a ('0), .b (y), .sub (1'b1), .sum (y_neg), .cout (unused_cout_y)
    );
    CLA_AddSub #(.N(WIDTH)) u_neg_q (
        .a ('0), .b (quo), .sub (1'b1), .sum (q_neg), .cout (unused_cout_q)
    );
    CLA_AddSub #(.N(WIDTH)) u_neg_r (
        .a ('0), .b (rem), .sub (1'b1), .sum (r_neg), .cout (unused_cout_r)
    );

    // Operand magnitudes for capture and sign-corrected results for FIX.
    always_comb begin
        x_mag = x[WIDTH-1] ? x_neg : x;
        y_mag = y[WIDTH-1] ? y_neg : y;
        q_fix = neg_q ? q_neg : quo;
        r_fix = neg_r ? r_neg : rem;
    end

    // Result signs are latched at capture since the operands may change while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
            neg_r <= x[WIDTH-1];
        end
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        x_mag = x;
        y_mag = y;
        q_fix = quo;
        r_fix = rem;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for start, RUN runs WIDTH iterations, FIX lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers. A zero divisor leaves the remainder equal to the
    // dividend on its own, so only the quotient needs overriding.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs  <= y_mag;
                        quo  <= x_mag;
                        rem  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    rem <= no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], no_borrow};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    q       <= (dvs == '0) ? {WIDTH{DIV_ZERO_Q_FILL}} : q_fix;
                    r       <= r_fix;
                    divZero <= (dvs == '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_div.sv
// Self-checking bench for cla_seq_div (WIDTH=32): directed cases plus random
// operands compared against a plain-arithmetic reference model.
// Expected values follow CLA_SEQ_DIV_SIGNED_EN when it is defined.
module tb_cla_seq_div;

    localparam int W     = 32;
    localparam int LAT   = W + 1;
    localparam int LIMIT = 100;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         divZero;

    int total_checks;
    int passed_checks;

    cla_seq_div #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .q       (q),
        .r       (r),
        .divZero (divZero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one start cycle; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] ax, input logic [W-1:0] ay);
        x     = ax;
        y     = ay;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded by LIMIT.
    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < LIMIT);
    endtask

    // Reference: quotient/remainder from the division rules with plain arithmetic.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] eq, output logic [W-1:0] er,
                                   output logic ez);
        int sa;
        int sb;
        ez = (b == 0);
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin
            eq = '1;
            er = a;
        end else begin
`ifdef CLA_SEQ_DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                eq = 32'h8000_0000;
                er = '0;
            end else begin
                eq = sa / sb;
                er = sa % sb;
            end
`else
            eq = a / b;
            er = a % b;
`endif
        end
    endfunction

    initial begin
        int           lat;
        int           dones;
        int           seen_lat;
        logic [W-1:0] seen_q;
        logic [W-1:0] seen_r;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        total_checks  = 0;
        passed_checks = 0;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_q", q, 32'd0);
        checkOutput("reset_r", r, 32'd0);
        checkOutput("reset_divzero", {31'b0, divZero}, 32'd0);

        // 100 / 7 with latency and single-cycle done.
        applyStimulus(32'd100, 32'd7);
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        waitDone(lat);
        checkOutput("lat_100_7", 32'(lat), 32'(LAT));
        checkOutput("q_100_7", q, 32'd14);
        checkOutput("r_100_7", r, 32'd2);
        checkOutput("dz_100_7", {31'b0, divZero}, 32'd0);
        checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
        checkOutput("q_held", q, 32'd14);

        // Back-to-back: second start asserted in the done cycle.
        applyStimulus(32'hFFFF_FFFF, 32'd1);
        waitDone(lat);
        checkOutput("lat_ffff_1", 32'(lat), 32'(LAT));
`ifdef CLA_SEQ_DIV_SIGNED_EN
        checkOutput("q_ffff_1", q, 32'hFFFF_FFFF);
        checkOutput("r_ffff_1", r, 32'd0);
`else
        checkOutput("q_ffff_1", q, 32'hFFFF_FFFF);
        checkOutput("r_ffff_1", r, 32'd0);
`endif
        applyStimulus(32'h10, 32'd3);
        checkOutput("b2b_accepted_busy", {31'b0, busy}, 32'd1);
        checkOutput("b2b_done_dropped", {31'b0, done}, 32'd0);
        checkOutput("b2b_q_not_cleared", q, 32'hFFFF_FFFF);
        waitDone(lat);
        checkOutput("lat_b2b", 32'(lat), 32'(LAT));
        checkOutput("q_10_3", q, 32'd5);
        checkOutput("r_10_3", r, 32'd1);

        // Divide by zero.
        applyStimulus(32'h1234, 32'd0);
        waitDone(lat);
        checkOutput("lat_div0", 32'(lat), 32'(LAT));
        checkOutput("q_div0", q, 32'hFFFF_FFFF);
        checkOutput("r_div0", r, 32'h1234);
        checkOutput("dz_div0", {31'b0, divZero}, 32'd1);

        // Starts while busy are ignored.
        applyStimulus(32'd100, 32'd7);
        dones    = 0;
        seen_lat = 0;
        seen_q   = '0;
        seen_r   = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (cyc == 5 || cyc == 20) begin
                x     = $urandom;
                y     = $urandom_range(1, 50);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                seen_lat = cyc;
                seen_q   = q;
                seen_r   = r;
            end
        end
        start = 1'b0;
        checkOutput("ignore_start_dones", 32'(dones), 32'd1);
        checkOutput("ignore_start_lat", 32'(seen_lat), 32'(LAT));
        checkOutput("ignore_start_q", seen_q, 32'd14);
        checkOutput("ignore_start_r", seen_r, 32'd2);

        // Reset mid-division aborts without a done.
        applyStimulus(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_q", q, 32'd0);
        checkOutput("abort_r", r, 32'd0);
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);

        // Sign handling: -7 / 2.
        applyStimulus(32'hFFFF_FFF9, 32'd2);
        waitDone(lat);
`ifdef CLA_SEQ_DIV_SIGNED_EN
        checkOutput("q_m7_2", q, 32'hFFFF_FFFD);
        checkOutput("r_m7_2", r, 32'hFFFF_FFFF);
`else
        checkOutput("q_m7_2", q, 32'h7FFF_FFFC);
        checkOutput("r_m7_2", r, 32'd1);
`endif

        // Most negative dividend by all ones.
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(lat);
        refDiv(32'h8000_0000, 32'hFFFF_FFFF, eq, er, ez);
        checkOutput("q_min_m1", q, eq);
        checkOutput("r_min_m1", r, er);

        // Random operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 4))
                0:       ry = $urandom;
                1:       ry = $urandom_range(1, 15);
                2:       ry = $urandom & 32'h0000_FFFF;
                3:       ry = 32'd0 - $urandom_range(1, 15);
                default: ry = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(1, 31));
            endcase
            applyStimulus(rx, ry);
            waitDone(lat);
            refDiv(rx, ry, eq, er, ez);
            checkOutput("rand_lat", 32'(lat), 32'(LAT));
            checkOutput("rand_q", q, eq);
            checkOutput("rand_r", r, er);
            checkOutput("rand_dz", {31'b0, divZero}, {31'b0, ez});
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
